pi2_bpsk_demapper: RTL and testbench

//  Downstream companion of the pi/2-BPSK modulation stage: takes Q1.15 I/Q symbols,

---
 rtl/pi2_bpsk_demapper.sv | 158 +++++++++++++++
 tb/tb_pi2_bpsk_demapper.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pi2_bpsk_demapper.sv
// pi/2-BPSK hard-decision demapper: de-rotates by symbol parity, packs bits MSB first
// into bytes and queues them in a small FWFT FIFO behind an AXI-Stream master.
// Optional LOW_CONF_CNT_EN macro adds a saturating low-confidence symbol counter.
module pi2_bpsk_demapper #(
    parameter int unsigned FIFO_DEPTH = 4
`ifdef LOW_CONF_CNT_EN
    , parameter int unsigned THRESH = 8192
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_tvalid,
    input  logic               s_sync,
    input  logic signed [15:0] s_real,
    input  logic signed [15:0] s_imag,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [7:0]         m_tdata,
    output logic               overflow,
    output logic [15:0]        low_conf_cnt
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    // Stage 1: parity, metric and hard decision
    logic               odd_q, odd_c;
    logic signed [16:0] re_x_c, im_x_c, metric_c;
    logic               bit_c;
    logic               d_valid_q, d_bit_q, d_sync_q;

    always_comb begin
        odd_c    = odd_q & ~s_sync;
        re_x_c   = {s_real[15], s_real};
        im_x_c   = {s_imag[15], s_imag};
        metric_c = odd_c ? (im_x_c - re_x_c) : (re_x_c + im_x_c);
        bit_c    = (metric_c > 17'sd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            odd_q     <= 1'b0;
            d_valid_q <= 1'b0;
            d_bit_q   <= 1'b0;
            d_sync_q  <= 1'b0;
        end else begin
            d_valid_q <= s_tvalid;
            if (s_tvalid) begin
                odd_q    <= ~odd_c;
                d_bit_q  <= bit_c;
                d_sync_q <= s_sync;
            end
        end
    end

    // Stage 2: bit packing; a sync symbol restarts the byte at bit 7
    logic [6:0] acc_q, acc_d, acc_base_c;
    logic [2:0] bit_cnt_q, bit_cnt_d, cnt_base_c;
    logic       push_c;
    logic [7:0] push_byte_c;

    always_comb begin
        acc_base_c  = d_sync_q ? 7'd0 : acc_q;
        cnt_base_c  = d_sync_q ? 3'd0 : bit_cnt_q;
        acc_d       = acc_q;
        bit_cnt_d   = bit_cnt_q;
        push_c      = 1'b0;
        push_byte_c = {acc_base_c, d_bit_q};
        if (d_valid_q) begin
            acc_d     = {acc_base_c[5:0], d_bit_q};
            bit_cnt_d = cnt_base_c + 3'd1;
            push_c    = (cnt_base_c == 3'd7);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= 7'd0;
            bit_cnt_q <= 3'd0;
        end else begin
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Output FIFO; head and valid are registered from next-state values
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_c, full_c, wr_en_c, drop_c;
    logic [7:0]    head_d;
    logic          m_tvalid_q, overflow_q;
    logic [7:0]    m_tdata_q;

    always_comb begin
        pop_c    = m_tvalid_q & m_tready;
        full_c   = (count_q == CW'(FIFO_DEPTH));
        wr_en_c  = push_c & (~full_c | pop_c);
        drop_c   = push_c & full_c & ~pop_c;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_c)   rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_q + CW'(wr_en_c) - CW'(pop_c);
        // New head is the byte being written when the queue was (or becomes) empty
        if (wr_en_c && (rd_ptr_d == wr_ptr_q)) head_d = push_byte_c;
        else                                   head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[wr_ptr_q] <= push_byte_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= 8'd0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            m_tvalid_q <= (count_d != '0);
            m_tdata_q  <= head_d;
            if (drop_c) overflow_q <= 1'b1;
        end
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tdata  = m_tdata_q;
    assign overflow = overflow_q;

`ifdef LOW_CONF_CNT_EN
    logic [16:0] abs_c, d_abs_q;
    logic [15:0] low_conf_q;

    assign abs_c = metric_c[16] ? 17'(-metric_c) : 17'(metric_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_abs_q    <= 17'd0;
            low_conf_q <= 16'd0;
        end else begin
            if (s_tvalid) d_abs_q <= abs_c;
            if (d_valid_q && (d_abs_q < 17'(THRESH)) && (low_conf_q != 16'hFFFF))
                low_conf_q <= low_conf_q + 16'd1;
        end
    end

    assign low_conf_cnt = low_conf_q;
`else
    assign low_conf_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pi2_bpsk_demapper.sv
// Self-checking bench for pi2_bpsk_demapper: directed scenarios plus randomized symbols
// checked against a parity/metric/byte-queue reference model.
module tb_pi2_bpsk_demapper;

    localparam int unsigned DEPTH = 4;
    localparam int          TH    = 8192;
    localparam int          A     = 23171;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_tvalid, s_sync, m_tready;
    logic signed [15:0] s_real, s_imag;
    logic               m_tvalid, overflow;
    logic [7:0]         m_tdata;
    logic [15:0]        low_conf_cnt;

    pi2_bpsk_demapper #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_sync(s_sync), .s_real(s_real), .s_imag(s_imag),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .overflow(overflow), .low_conf_cnt(low_conf_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic       m_odd;
    int         m_nb;
    logic [7:0] m_byte;
    logic       m_hold;
    int         m_occ;
    logic       m_ovf;
    int         m_lc;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) got_q.push_back(m_tdata);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] exp_lc();
`ifdef LOW_CONF_CNT_EN
        return 16'(m_lc);
`else
        return 16'd0;
`endif
    endfunction

    task automatic model_reset();
        m_odd = 1'b0; m_nb = 0; m_byte = 8'd0; m_hold = 1'b0;
        m_occ = 0; m_ovf = 1'b0; m_lc = 0;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic model_push(input logic [7:0] b);
        if (m_hold) begin
            if (m_occ < int'(DEPTH)) begin exp_q.push_back(b); m_occ++; end
            else m_ovf = 1'b1;
        end else exp_q.push_back(b);
    endtask

    // Drive one valid symbol for a cycle and advance the model
    task automatic send(input logic signed [15:0] re, input logic signed [15:0] im,
                        input logic sync);
        int rv, iv, met, mag;
        logic odd;
        s_tvalid = 1'b1; s_sync = sync; s_real = re; s_imag = im;
        odd = sync ? 1'b0 : m_odd;
        rv = re; iv = im;
        met = odd ? (iv - rv) : (rv + iv);
        mag = (met < 0) ? -met : met;
        if (sync) m_nb = 0;
        m_byte = {m_byte[6:0], (met > 0)};
        m_nb++;
        if (m_nb == 8) begin m_nb = 0; model_push(m_byte); end
        m_odd = ~odd;
        if (mag < TH && m_lc < 65535) m_lc++;
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input logic b, input logic sync);
        logic odd;
        odd = sync ? 1'b0 : m_odd;
        if (!odd) send(b ? 16'(A) : 16'(-A), b ? 16'(A) : 16'(-A), sync);
        else      send(b ? 16'(-A) : 16'(A), b ? 16'(A) : 16'(-A), sync);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic sync_first);
        for (int i = 7; i >= 0; i--) send_bit(v[i], (i == 7) ? sync_first : 1'b0);
    endtask

    task automatic idle(input int n, input logic sync_noise);
        s_tvalid = 1'b0; s_sync = sync_noise;
        repeat (n) begin @(posedge clk); #1; end
        s_sync = 1'b0;
    endtask

    task automatic cmp_out(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        logic signed [15:0] rv, iv;
        int mode;
        rst = 1'b1; s_tvalid = 1'b0; s_sync = 1'b0; s_real = '0; s_imag = '0; m_tready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_lowconf", 32'(low_conf_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single byte 0xB2 and its latency
        send_byte(8'hB2, 1'b0);
        chk("lat_not_yet", 32'(m_tvalid), 32'd0);
        idle(1, 1'b0);
        chk("lat_tvalid", 32'(m_tvalid), 32'd1);
        chk("lat_tdata", 32'(m_tdata), 32'hB2);
        idle(3, 1'b0);
        chk("b2_model", 32'(exp_q.size()), 32'd1);
        cmp_out("byte_b2");

        // Back-to-back 0x00 then 0xFF
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        idle(4, 1'b0);
        cmp_out("b2b");
        chk("b2b_overflow", 32'(overflow), 32'd0);

        // FIFO full with ready low: one byte dropped
        m_tready = 1'b0; m_hold = 1'b1; m_occ = 0;
        for (int i = 0; i < int'(DEPTH + 1) * 8; i++) send_bit(1'($urandom), 1'b0);
        idle(3, 1'b0);
        chk("full_overflow", 32'(overflow), 32'(m_ovf));
        chk("full_tvalid", 32'(m_tvalid), 32'd1);
        chk("full_head", 32'(m_tdata), 32'(exp_q[0]));
        idle(5, 1'b0);
        chk("full_head_stable", 32'(m_tdata), 32'(exp_q[0]));
        m_tready = 1'b1; m_hold = 1'b0;
        idle(10, 1'b0);
        chk("full_drained", 32'(got_q.size()), 32'(DEPTH));
        cmp_out("full");
        chk("full_empty", 32'(m_tvalid), 32'd0);

        // Partial byte discarded by sync
        for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b0);
        send_byte(8'hA5, 1'b1);
        idle(4, 1'b0);
        chk("sync_model", 32'(exp_q.size()), 32'd1);
        cmp_out("sync_a5");
        chk("sync_overflow", 32'(overflow), 32'(m_ovf));

        // Zero metric at EVEN decides 0; small metric counts as low confidence
        chk("lc_before", 32'(low_conf_cnt), 32'(exp_lc()));
        send(16'sd0, 16'sd0, 1'b1);
        send(-16'sd50, 16'sd50, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(1'(i), 1'b0);
        idle(4, 1'b0);
        cmp_out("zero_metric");
        chk("lc_after", 32'(low_conf_cnt), 32'(exp_lc()));

        // Reset mid-byte with bytes queued
        m_tready = 1'b0; m_hold = 1'b1; m_occ = 0;
        for (int i = 0; i < 19; i++) send_bit(1'($urandom), 1'b0);
        idle(2, 1'b0);
        chk("pre_rst_tvalid", 32'(m_tvalid), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        chk("midrst_lowconf", 32'(low_conf_cnt), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; m_tready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send_bit(1'($urandom), 1'b0);
        idle(4, 1'b0);
        chk("post_rst_model", 32'(exp_q.size()), 32'd1);
        cmp_out("post_rst");

        // Randomized symbols, gaps, syncs and ready
        for (int n = 0; n < 400; n++) begin
            m_tready = ($urandom % 4) != 0;
            if ($urandom % 4 == 0) idle(1 + int'($urandom % 2), 1'($urandom));
            mode = int'($urandom % 4);
            case (mode)
                0: begin rv = 16'($urandom); iv = 16'($urandom); end
                1: begin rv = 16'($urandom_range(0, 400) - 200); iv = 16'($urandom_range(0, 400) - 200); end
                2: begin rv = 16'($urandom); iv = rv; end
                default: begin rv = ($urandom % 2) ? 16'(A) : 16'(-A); iv = ($urandom % 2) ? 16'(A) : 16'(-A); end
            endcase
            send(rv, iv, ($urandom % 16) == 0);
        end
        m_tready = 1'b1;
        idle(12, 1'b0);
        cmp_out("rand");
        chk("rand_overflow", 32'(overflow), 32'(m_ovf));
        chk("rand_lowconf", 32'(low_conf_cnt), 32'(exp_lc()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
